// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide sequencer.
// Provides the funct3 op codes, the sequencer state encoding and small
// helpers that decode operand signedness from the op code.
package muldiv_seq_pkg;

  // funct3 codes of the RV32M instructions
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIN  = 2'b10
  } md_state_e;

  // Divide family occupies the upper half of the funct3 space
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Operand A is signed for MUL/MULH/MULHSU/DIV/REM
  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Operand B is signed for MUL/MULH/DIV/REM
  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Remainder ops take the dividend's sign instead of the xor of both signs
  function automatic logic md_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide loop.
//   acc_i      : {high word, low word} working accumulator
//   operand_i  : multiplicand (multiply) or divisor magnitude (divide)
//   div_mode_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_o      : next accumulator (divide: low bit left 0, see q_bit_o)
//   q_bit_o    : quotient bit produced by a divide step (0 when multiplying)
// Multiply: low word holds the remaining multiplier bits; the product grows
// in from the top as the pair shifts right.
// Divide: high word is the partial remainder, low word shifts the dividend
// out at the top while quotient bits enter at bit 0.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  input  logic              div_mode_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    rem_sh  = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
    // rem_sh < 2*divisor, so bit XLEN of the difference is a clean borrow flag
    diff    = rem_sh - {1'b0, operand_i};
    q_bit_o = 1'b0;
    acc_o   = {sum, acc_i[XLEN-1:1]};
    if (div_mode_i) begin
      q_bit_o = ~diff[XLEN];
      acc_o   = {(diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0]),
                 acc_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer.
// Accepts one op per start pulse in IDLE, iterates XLEN cycles over operand
// magnitudes, applies the sign fix in FIN and strobes result_valid once.
// Divide-by-zero and signed overflow bypass the loop (latency 1).
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, op         : issue request and funct3
//   rs1_data/rs2_data : operands A and B, sampled only on acceptance
//   flush             : abort any in-flight operation
//   busy, stall       : sequencer occupied / hold the core
//   result            : last result (held), result_valid one-cycle strobe
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] result,
  output logic            result_valid
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   b_mag_q, b_mag_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              rv_q, rv_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, accept;
  logic [2*XLEN-1:0] step_acc, prod_fix;
  logic              step_q;
  logic [XLEN-1:0]   lo_fix, hi_fix, fin_val, fast_val;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc_i      (acc_q),
    .operand_i  (b_mag_q),
    .div_mode_i (md_is_div(op_q)),
    .acc_o      (step_acc),
    .q_bit_o    (step_q)
  );

  // Operand decode for the issue cycle
  always_comb begin
    a_neg    = md_a_signed(op) & rs1_data[XLEN-1];
    b_neg    = md_b_signed(op) & rs2_data[XLEN-1];
    a_mag    = a_neg ? (~rs1_data + 1'b1) : rs1_data;
    b_mag    = b_neg ? (~rs2_data + 1'b1) : rs2_data;
    div_zero = (rs2_data == '0);
    div_ovf  = ((op == MD_DIV) || (op == MD_REM)) && (rs1_data == SMIN) && (rs2_data == '1);
    accept   = start & ~flush & ~rv_q & (state_q == MD_IDLE);
    // Fast-path answers: x/0 = all ones, x%0 = x; MIN/-1 = MIN, MIN%-1 = 0
    if (div_zero) fast_val = md_is_rem(op) ? rs1_data : '1;
    else          fast_val = md_is_rem(op) ? '0 : SMIN;
  end

  // Sign fix and word select; neg_q already encodes the op-specific rule
  always_comb begin
    prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    lo_fix   = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    hi_fix   = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MD_MUL:                       fin_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fin_val = lo_fix;
      default:                      fin_val = hi_fix;
    endcase
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    b_mag_d  = b_mag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    rv_d     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          op_d    = op;
          b_mag_d = b_mag;
          acc_d   = {{XLEN{1'b0}}, a_mag};
          cnt_d   = '0;
          neg_d   = md_is_rem(op) ? a_neg : (a_neg ^ b_neg);
          if (md_is_div(op) && (div_zero || div_ovf)) begin
            result_d = fast_val;
            rv_d     = 1'b1;
            state_d  = MD_FIN;
          end else begin
            state_d  = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = md_is_div(op_q) ? {step_acc[2*XLEN-1:1], step_q} : step_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) state_d = MD_FIN;
        end
      end
      MD_FIN: begin
        state_d = MD_IDLE;
        // rv_q high here means the fast path already delivered its result
        if (!flush && !rv_q) begin
          result_d = fin_val;
          rv_d     = 1'b1;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      b_mag_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      b_mag_q  <= b_mag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign busy         = (state_q != MD_IDLE);
  assign stall        = (start & (state_q == MD_IDLE)) | (busy & ~rv_q);
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule
